// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared state encoding and default LFSR parameters for the pattern checker.
package lfsr_pkg;
  typedef enum logic [1:0] {FILL, VERIFY, LOCKED} chk_state_t;
  localparam int LFSR_W = 8;
  localparam logic [7:0] LFSR_TAPS_DEF = 8'hC3;
endpackage

// File: rtl/lfsr_history.sv
// lfsr_history: WIDTH-bit received/predicted history with TAPS XOR predictor.
module lfsr_history import lfsr_pkg::*; #(
  parameter int WIDTH = LFSR_W,
  parameter logic [WIDTH-1:0] TAPS = LFSR_TAPS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift,
  input  logic             sel_rx,
  input  logic             bit_in,
  output logic             pred,
  output logic [WIDTH-1:0] hist_nxt
);
  logic [WIDTH-1:0] hist_q, hist_d;
  always_comb begin
    pred = ^(hist_q & TAPS);
    hist_d = clr ? '0 : shift ? {hist_q[WIDTH-2:0], sel_rx ? bit_in : pred} : hist_q;
    hist_nxt = hist_d;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hist_q <= '0;
    else hist_q <= hist_d;
endmodule

// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising LFSR sequence checker with lock FSM and error counter.
// LFSR_CHK_SAT_EN makes err_count saturate instead of wrapping.
module lfsr_checker import lfsr_pkg::*; #(
  parameter int WIDTH = LFSR_W,
  parameter logic [WIDTH-1:0] TAPS = LFSR_TAPS_DEF,
  parameter int LOCK_CNT = 16,
  parameter int LOSS_ERR = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             resync,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);
  localparam int FW = $clog2(WIDTH + 1);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOSS_ERR + 1);
  chk_state_t state_q, state_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [GW-1:0] good_q, good_d;
  logic [BW-1:0] bad_q, bad_d;
  logic [CNT_W-1:0] err_count_q, err_count_d, cnt_inc;
  logic locked_q, locked_d, err_pulse_q;
  logic pred, match, adv, miss, lose, sel_rx;
  logic [WIDTH-1:0] hist_nxt;
  assign match = bit_in == pred;
  assign adv = bit_valid && !resync;
  assign miss = adv && state_q == LOCKED && !match;
  assign lose = miss && bad_q == BW'(LOSS_ERR - 1);
  // On loss of lock the received bit, not the prediction, enters the history.
  assign sel_rx = state_q != LOCKED || lose;
  lfsr_history #(.WIDTH(WIDTH), .TAPS(TAPS)) u_hist (
    .clk(clk), .rst_n(rst_n), .clr(resync), .shift(adv), .sel_rx(sel_rx),
    .bit_in(bit_in), .pred(pred), .hist_nxt(hist_nxt)
  );
  always_comb begin
    state_d = state_q;
    fill_d = fill_q;
    good_d = good_q;
    bad_d = bad_q;
    if (resync) begin
      state_d = FILL;
      fill_d = '0;
      good_d = '0;
      bad_d = '0;
    end else if (bit_valid) begin
      case (state_q)
        FILL: begin
          fill_d = fill_q + 1'b1;
          if (fill_q == FW'(WIDTH - 1)) begin
            state_d = VERIFY;
            fill_d = '0;
            good_d = '0;
          end
        end
        VERIFY: begin
          good_d = !match ? '0 : good_q == GW'(LOCK_CNT) ? good_q : good_q + 1'b1;
          if (good_d == GW'(LOCK_CNT) && hist_nxt != '0) begin
            state_d = LOCKED;
            good_d = '0;
            bad_d = '0;
          end
        end
        LOCKED: begin
          good_d = !match || good_q == GW'(LOCK_CNT - 1) ? '0 : good_q + 1'b1;
          bad_d = !match ? (lose ? '0 : bad_q + 1'b1) : good_q == GW'(LOCK_CNT - 1) ? '0 : bad_q;
          state_d = lose ? VERIFY : LOCKED;
        end
        default: state_d = FILL;
      endcase
    end
  end
`ifdef LFSR_CHK_SAT_EN
  assign cnt_inc = &err_count_q ? err_count_q : err_count_q + 1'b1;
`else
  assign cnt_inc = err_count_q + 1'b1;
`endif
  assign err_count_d = clr_cnt ? {{(CNT_W-1){1'b0}}, miss} : miss ? cnt_inc : err_count_q;
  assign locked_d = state_d == LOCKED;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= FILL;
      fill_q <= '0;
      good_q <= '0;
      bad_q <= '0;
      err_count_q <= '0;
      locked_q <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q <= fill_d;
      good_q <= good_d;
      bad_q <= bad_d;
      err_count_q <= err_count_d;
      locked_q <= locked_d;
      err_pulse_q <= miss;
    end
  assign locked = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: vector table, directed lock/loss/saturation sequences and randomized
// streams checked against a queue-based model; runs a 16-bit and a 4-bit counter instance.
module tb_lfsr_checker;
  localparam logic [7:0] TAPS = 8'hC3;
  localparam int LOCK = 16;
  localparam int LOSS = 4;
  localparam int M_FILL = 0, M_VER = 1, M_LOCK = 2;
  logic clk = 0, rst_n = 0, bit_valid = 0, bit_in = 0, resync = 0, clr_cnt = 0;
  logic locked, err_pulse, locked4, err_pulse4;
  logic [15:0] err_count;
  logic [3:0] err_count4;
  int checks = 0, failures = 0;
  bit q[$];
  int mode, fill, good, bad, cnt16, cnt4;
  bit m_pulse;
  logic [7:0] g;
  typedef struct {bit v, b, rs, cl, el, ep; int ec;} vec_t;
  vec_t tbl[10];

  always #5 clk = ~clk;

  lfsr_checker dut (.clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in),
    .resync(resync), .clr_cnt(clr_cnt), .locked(locked), .err_pulse(err_pulse), .err_count(err_count));
  lfsr_checker #(.CNT_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in),
    .resync(resync), .clr_cnt(clr_cnt), .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4));

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
    end
  endtask

  function automatic int inc(int c, int w);
`ifdef LFSR_CHK_SAT_EN
    return (c == (1 << w) - 1) ? c : c + 1;
`else
    return (c + 1) % (1 << w);
`endif
  endfunction

  function automatic bit m_pred();
    bit p = 0;
    for (int k = 0; k < 8; k++) if (TAPS[k]) p ^= q[k];
    return p;
  endfunction

  function automatic bit m_nonzero();
    foreach (q[k]) if (q[k]) return 1;
    return 0;
  endfunction

  task automatic push(bit x);
    q.push_front(x);
    void'(q.pop_back());
  endtask

  task automatic m_reset();
    q.delete();
    repeat (8) q.push_back(0);
    mode = M_FILL; fill = 0; good = 0; bad = 0; cnt16 = 0; cnt4 = 0; m_pulse = 0;
  endtask

  task automatic m_step(bit v, bit b, bit rs, bit cl);
    bit err = 0, p;
    if (rs) begin
      for (int k = 0; k < 8; k++) q[k] = 0;
      mode = M_FILL; fill = 0; good = 0; bad = 0;
    end else if (v) begin
      p = m_pred();
      if (mode == M_FILL) begin
        push(b);
        fill++;
        if (fill == 8) begin mode = M_VER; fill = 0; good = 0; end
      end else if (mode == M_VER) begin
        good = (b == p) ? ((good < LOCK) ? good + 1 : good) : 0;
        push(b);
        if (good == LOCK && m_nonzero()) begin mode = M_LOCK; good = 0; bad = 0; end
      end else if (b != p) begin
        err = 1; bad++; good = 0;
        if (bad == LOSS) begin mode = M_VER; bad = 0; push(b); end
        else push(p);
      end else begin
        good++;
        if (good == LOCK) begin good = 0; bad = 0; end
        push(p);
      end
    end
    if (cl) begin cnt16 = err; cnt4 = err; end
    else if (err) begin cnt16 = inc(cnt16, 16); cnt4 = inc(cnt4, 4); end
    m_pulse = err;
  endtask

  function automatic logic gen();
    logic nb = ^(g & TAPS);
    g = {g[6:0], nb};
    return nb;
  endfunction

  task automatic cyc(bit v, bit b, bit rs, bit cl);
    bit_valid = v; bit_in = b; resync = rs; clr_cnt = cl;
    @(posedge clk);
    m_step(v, b, rs, cl);
    @(negedge clk);
    check("locked", locked, mode == M_LOCK);
    check("err_pulse", err_pulse, m_pulse);
    check("err_count", err_count, cnt16);
    check("locked4", locked4, mode == M_LOCK);
    check("err_pulse4", err_pulse4, m_pulse);
    check("err_count4", err_count4, cnt4);
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    check("rst_locked", locked, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_err_count", err_count, 0);
    check("rst_err_count4", err_count4, 0);
    m_reset();
    #1 rst_n = 1;
  endtask

  initial begin
    int n;
    bit f, v, b;
    m_reset();
    @(negedge clk);
    do_reset();
    // 8 ones fill the history; the following 0 matches pred=0 and is never an error
    for (int i = 0; i < 8; i++) tbl[i] = '{1, 1, 0, 0, 0, 0, 0};
    tbl[8] = '{1, 0, 0, 0, 0, 0, 0};
    tbl[9] = '{0, 0, 0, 1, 0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].v, tbl[i].b, tbl[i].rs, tbl[i].cl);
      check("tbl_locked", locked, tbl[i].el);
      check("tbl_err_pulse", err_pulse, tbl[i].ep);
      check("tbl_err_count", err_count, tbl[i].ec);
    end
    // clean stream locks one cycle after bit 24
    do_reset();
    g = 8'h01;
    for (int i = 1; i <= 24; i++) begin
      cyc(1, gen(), 0, 0);
      check("lock_time", locked, i == 24);
    end
    // single flipped bit while locked
    cyc(1, !gen(), 0, 0);
    check("flip_pulse", err_pulse, 1);
    check("flip_count", err_count, 1);
    check("flip_locked", locked, 1);
    cyc(1, gen(), 0, 0);
    check("flip_pulse_drop", err_pulse, 0);
    for (int i = 0; i < 20; i++) cyc(1, gen(), 0, 0);
    check("flip_no_more", err_count, 1);
    // 4 errors within 10 bits drop lock, then relock
    cyc(0, 0, 0, 1);
    check("clr_count", err_count, 0);
    for (int i = 0; i < 10; i++) begin
      f = (i == 0 || i == 2 || i == 5 || i == 9);
      cyc(1, gen() ^ f, 0, 0);
      if (i < 9) check("loss_still_locked", locked, 1);
    end
    check("loss_unlocked", locked, 0);
    check("loss_count", err_count, 4);
    n = 0;
    while (!locked && n < 40) begin cyc(1, gen(), 0, 0); n++; end
    check("relock_in_bound", locked, 1);
    // all-zero stream never locks; resync drops its own bit
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 40; i++) begin
      cyc(1, 0, 0, 0);
      check("zeros_unlocked", locked, 0);
    end
    check("zeros_count", err_count, 4);
    cyc(1, 1, 1, 0);
    g = 8'h01;
    for (int i = 1; i <= 24; i++) begin
      cyc(1, gen(), 0, 0);
      check("resync_lock_time", locked, i == 24);
    end
    // counter wrap / saturation with 16 errors on the 4-bit instance
    do_reset();
    g = 8'h01;
    repeat (24) cyc(1, gen(), 0, 0);
    for (int k = 0; k < 16; k++) begin
      cyc(1, !gen(), 0, 0);
      repeat (16) cyc(1, gen(), 0, 0);
    end
    check("sat_locked", locked, 1);
    check("cnt16_after16", err_count, 16);
`ifdef LFSR_CHK_SAT_EN
    check("cnt4_after16", err_count4, 15);
`else
    check("cnt4_after16", err_count4, 0);
`endif
    cyc(1, !gen(), 0, 1);
    check("clr_with_miss", err_count4, 1);
    cyc(0, 0, 0, 1);
    check("clr_cnt4", err_count4, 0);
    // randomized traffic with occasional errors, resyncs, clears and resets
    for (int i = 0; i < 3000; i++) begin
      v = $urandom_range(3) != 0;
      b = v ? (gen() ^ ($urandom_range(39) == 0)) : 1'($urandom_range(1));
      cyc(v, b, $urandom_range(299) == 0, $urandom_range(99) == 0);
      if ($urandom_range(999) == 0) do_reset();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
